divider_seq: RTL and testbench
==============================

DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 Parameter WIDTH, default 32, sets operand and result width in bits.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair valid.
REQ-005 in_ready  output  1  divider can accept an operand pair.
REQ-006 is_signed  input  1  1 = DIV/REM two's-complement; 0 = DIVU/REMU; sampled on acceptance.
REQ-007 dividend  input  WIDTH  dividend; sampled on acceptance.
REQ-008 divisor  input  WIDTH  divisor; sampled on acceptance.
REQ-009 flush  input  1  synchronous abort of any operation in progress.
REQ-010 out_valid  output  1  quotient/remainder valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 quotient  output  WIDTH  result quotient.
REQ-013 remainder  output  WIDTH  result remainder.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Acceptance SHALL occur on a cycle where the state is IDLE, in_valid=1 and flush=0.
REQ-016 On acceptance of a normal case, the block SHALL latch the operand magnitudes and result signs, clear the step counter, and enter CALC.
REQ-017 Each CALC cycle SHALL perform one restoring step: shift the partial remainder left by one and bring in the next dividend MSB, then subtract the divisor magnitude. A non-negative difference SHALL be kept with quotient bit 1. A negative difference SHALL be discarded with quotient bit 0.
REQ-018 After exactly WIDTH CALC cycles, the block SHALL apply sign correction and enter DONE. The quotient SHALL be negated if the operand signs differ. The remainder SHALL take the sign of the dividend. out_valid SHALL be first high WIDTH+1 cycles after the acceptance edge.
REQ-019 Divide-by-zero (divisor=0) SHALL skip CALC and enter DONE on the cycle after acceptance, with quotient = all ones and remainder = dividend, for both signed and unsigned operation.
REQ-020 Signed overflow (is_signed=1, dividend = minimum negative value, divisor = all ones) SHALL skip CALC and enter DONE on the cycle after acceptance, with quotient = dividend and remainder = 0.
REQ-021 In DONE, quotient and remainder SHALL hold stable while out_ready=0. When out_ready=1, the block SHALL return to IDLE on the next edge; a new operand pair SHALL NOT be accepted in that same cycle.
REQ-022 flush=1 in any state SHALL force IDLE on the next edge and discard the result. flush SHALL override both acceptance and out_ready.
REQ-023 All arithmetic SHALL be WIDTH+1 bits wide internally so the subtraction borrow is visible. No operand value SHALL produce X or an undefined result.

Reset
REQ-024 When rst_n=0, the block SHALL asynchronously enter IDLE and clear the counter to 0.
REQ-025 During and after reset, out_valid SHALL be 0, in_ready SHALL be 1, and quotient and remainder SHALL be 0.
REQ-026 Reset asserted during CALC or DONE SHALL discard the operation, with no result emitted after release.

Structure
REQ-027 A shared package SHALL hold the state enumeration (IDLE, CALC, DONE) and the default WIDTH constant.
REQ-028 The single restoring step SHALL be a combinational sub-module div_step, with inputs partial remainder, next bit and divisor, and outputs new remainder and quotient bit.
REQ-029 Counter width SHALL be clog2(WIDTH)+1 bits.

Verification
REQ-030 Unsigned, 100 / 7 -> quotient 14, remainder 2, out_valid 33 cycles after acceptance (WIDTH=32).
REQ-031 Signed, -7 / 2 -> quotient -3, remainder -1; and 7 / -2 -> quotient -3, remainder 1.
REQ-032 Any dividend / 0, in both modes -> quotient 0xFFFFFFFF, remainder = dividend, out_valid 1 cycle after acceptance.
REQ-033 Signed, 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, out_valid 1 cycle after acceptance.
REQ-034 out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready 0 throughout; out_ready=1 -> IDLE next cycle.
REQ-035 flush at CALC step 10, then rst_n pulse during a second CALC -> no out_valid for either operation; a third operation completes correctly.

Source files
------------

// File: rtl/divider_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states and default width.
package divider_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/divider_seq_if.sv
// Operand/result handshake bundle between a divider client (master) and the divider (slave).
interface divider_seq_if
    import divider_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output in_valid, is_signed, dividend, divisor, flush, out_ready,
        input  in_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  in_valid, is_signed, dividend, divisor, flush, out_ready,
        output in_ready, out_valid, quotient, remainder
    );

endinterface

// File: rtl/divider_seq_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step
    import divider_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The partial remainder is always below the divisor, so the MSB of the
    // WIDTH+1 bit difference is exactly the borrow of the trial subtraction.
    assign shifted = {rem_in, next_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule

// File: rtl/divider_seq.sv
// Multi-cycle signed/unsigned integer divider, one restoring step per clock.
module divider_seq
    import divider_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    divider_seq_if.slave   bus
);

    localparam int               CW      = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] dsr_mag;
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] rem_reg;

    logic             dvd_neg_in;
    logic             dsr_neg_in;
    logic [WIDTH-1:0] dvd_mag_in;
    logic [WIDTH-1:0] dsr_mag_in;
    logic             overflow_in;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] next_work;

    always_comb begin
        dvd_neg_in  = bus.is_signed & bus.dividend[WIDTH-1];
        dsr_neg_in  = bus.is_signed & bus.divisor[WIDTH-1];
        dvd_mag_in  = dvd_neg_in ? -bus.dividend : bus.dividend;
        dsr_mag_in  = dsr_neg_in ? -bus.divisor : bus.divisor;
        overflow_in = bus.is_signed && (bus.dividend == MIN_NEG) && (&bus.divisor);
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in   (part_rem),
        .next_bit (work[WIDTH-1]),
        .divisor  (dsr_mag),
        .rem_out  (step_rem),
        .q_bit    (step_q)
    );

    // Dividend bits leave the top of work while quotient bits enter at the bottom.
    assign next_work = {work[WIDTH-2:0], step_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            work     <= '0;
            part_rem <= '0;
            dsr_mag  <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            quo_reg  <= '0;
            rem_reg  <= '0;
        end else if (bus.flush) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.divisor == '0) begin
                            quo_reg <= '1;
                            rem_reg <= bus.dividend;
                            state   <= DONE;
                        end else if (overflow_in) begin
                            quo_reg <= bus.dividend;
                            rem_reg <= '0;
                            state   <= DONE;
                        end else begin
                            work     <= dvd_mag_in;
                            part_rem <= '0;
                            dsr_mag  <= dsr_mag_in;
                            q_neg    <= dvd_neg_in ^ dsr_neg_in;
                            r_neg    <= dvd_neg_in;
                            count    <= '0;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    work     <= next_work;
                    part_rem <= step_rem;
                    // The last step's result is sign-corrected on the same edge it is produced.
                    if (count == LAST) begin
                        quo_reg <= q_neg ? -next_work : next_work;
                        rem_reg <= r_neg ? -step_rem : step_rem;
                        state   <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.quotient  = quo_reg;
    assign bus.remainder = rem_reg;

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed vectors, handshake/abort sequences, random vs. arithmetic model.
module tb_divider_seq;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;

    divider_seq_if #(.WIDTH(W)) bus ();

    divider_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           lat;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        bus.is_signed = s;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Latency counts edges from the acceptance edge (inclusive) to the first out_valid.
    task automatic waitResult(output int lat);
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic releaseResult();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic runOp(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
        applyStimulus(s, a, b);
        waitResult(lat);
        q = bus.quotient;
        r = bus.remainder;
        releaseResult();
    endtask

    task automatic expectQuiet(input string name, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        checkOutput(name, 32'(seen), 32'd0);
    endtask

    // Reference: plain integer division (truncating, remainder follows dividend) plus the zero-divisor rule.
    function automatic void refDiv(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
        longint sa;
        longint sb;
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        if (b == '0) begin
            q   = '1;
            r   = a;
            lat = 1;
        end else begin
            q   = W'(sa / sb);
            r   = W'(sa % sb);
            lat = (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 1 : 33;
        end
    endfunction

    initial begin
        logic [W-1:0] q, r, eq, er;
        int lat, elat;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
        vecs[3] = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1};
        vecs[4] = '{1'b1, 32'h8000_0005,  32'd0,          32'hFFFF_FFFF,  32'h8000_0005,  1};
        vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1};
        vecs[6] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
        vecs[7] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
        vecs[8] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33};

        bus.in_valid  = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("reset quotient",  bus.quotient,       32'd0);
        checkOutput("reset remainder", bus.remainder,      32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post-reset in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < NV; i++) begin
            runOp(vecs[i].s, vecs[i].a, vecs[i].b, q, r, lat);
            checkOutput($sformatf("vec%0d quotient", i),  q, vecs[i].q);
            checkOutput($sformatf("vec%0d remainder", i), r, vecs[i].r);
            checkOutput($sformatf("vec%0d latency", i),   32'(lat), 32'(vecs[i].lat));
        end

        // Back-pressure in DONE, then release with a new request pending in the same cycle.
        applyStimulus(1'b0, 32'd1000, 32'd10);
        waitResult(lat);
        checkOutput("hold latency", 32'(lat), 32'd33);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("hold%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            checkOutput($sformatf("hold%0d in_ready", i),  32'(bus.in_ready),  32'd0);
            checkOutput($sformatf("hold%0d quotient", i),  bus.quotient,       32'd100);
            checkOutput($sformatf("hold%0d remainder", i), bus.remainder,      32'd0);
            @(negedge clk);
        end
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd50;
        bus.divisor   = 32'd5;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checkOutput("release out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("release no accept", 32'(bus.in_ready),  32'd1);

        // flush wins over acceptance in IDLE
        bus.dividend = 32'd9;
        bus.divisor  = 32'd0;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        @(negedge clk);
        checkOutput("flush idle in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("flush idle out_valid", 32'(bus.out_valid), 32'd0);

        // flush in DONE discards a result that was never consumed
        applyStimulus(1'b0, 32'd9, 32'd0);
        waitResult(lat);
        checkOutput("flush done pre out_valid", 32'(bus.out_valid), 32'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        checkOutput("flush done out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("flush done in_ready",  32'(bus.in_ready),  32'd1);

        // flush at CALC step 10
        applyStimulus(1'b0, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        checkOutput("calc in_ready", 32'(bus.in_ready), 32'd0);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        checkOutput("flush calc in_ready", 32'(bus.in_ready), 32'd1);
        expectQuiet("flush calc no result", 40);

        // asynchronous reset during a second CALC
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("async reset quotient",  bus.quotient,       32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        expectQuiet("reset calc no result", 40);

        runOp(1'b0, 32'd12345, 32'd67, q, r, lat);
        checkOutput("third op quotient",  q, 32'd184);
        checkOutput("third op remainder", r, 32'd17);
        checkOutput("third op latency",   32'(lat), 32'd33);

        for (int i = 0; i < 60; i++) begin
            logic         s;
            logic [W-1:0] a, b;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 9))
                0:       b = '0;
                1:       b = '1;
                2:       b = W'($urandom_range(1, 15));
                3: begin a = 32'h8000_0000; b = '1; end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            refDiv(s, a, b, eq, er, elat);
            runOp(s, a, b, q, r, lat);
            checkOutput($sformatf("rand%0d quotient s=%0d a=%08h b=%08h", i, s, a, b), q, eq);
            checkOutput($sformatf("rand%0d remainder s=%0d a=%08h b=%08h", i, s, a, b), r, er);
            checkOutput($sformatf("rand%0d latency", i), 32'(lat), 32'(elat));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
